// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment glyph table and polarity constants
package seg_pkg;

   // Segments a..g packed as bits [6:0], active-low
   typedef logic [6:0] seg_t;

   // Anode select polarity: a digit is driven when its enable bit is low
   localparam logic ENABLE_ON  = 1'b0;
   localparam logic ENABLE_OFF = 1'b1;

   // Dark levels for the segment and decimal-point lines
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam logic DP_OFF    = 1'b1;

   // Hex glyphs 0..F, index is the nibble value
   localparam seg_t SEG_TABLE [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

   // Table lookup shared by every display block
   function automatic seg_t hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational hex nibble to seven-segment decoder
module hex7seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   // Pure table lookup, no state
   always_comb begin
      seg_o = hex_to_seg(nibble_i);
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan with PWM brightness, blink and shadowed update
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int          NUM_DIGITS   = 8,
   parameter logic [31:0] SCAN_DIV     = 32'h20000,
   parameter int          BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] display,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic [2:0]              bright,
   input  logic                    upd_req,
   output logic                    upd_ack,
   output logic [NUM_DIGITS-1:0]   enable,
   output logic [6:0]              segs,
   output logic                    dp,
   output logic                    frame_done
);

   // Last legal digit index; the index wraps here even when NUM_DIGITS is not a power of two
   localparam logic [2:0] IDX_LAST   = 3'(NUM_DIGITS - 1);
   // Frame count at which the blink phase flips
   localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

   // Scan timing state
   logic [31:0]             prescale_q, prescale_d;
   logic [2:0]              sub_q, sub_d;
   logic [2:0]              idx_q, idx_d;

   // Blink state
   logic [7:0]              frame_q, frame_d;
   logic                    blink_off_q, blink_off_d;

   // Update handshake and shadow copy of the displayed content
   logic                    pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

   // Registered pin drivers
   logic [NUM_DIGITS-1:0]   enable_q, enable_d;
   seg_t                    segs_q, segs_d;
   logic                    dp_q, dp_d;

   // Internal events
   logic                    tick;
   logic                    sub_wrap;
   logic                    frame_wrap;
   logic                    capture;

   // Current-digit selection feeding the decoder
   logic [3:0]              nibble_sel;
   logic                    dp_sel;
   logic                    digit_lit;
   seg_t                    dec_seg;

   // Prescaler, PWM sub-phase and digit index advance
   always_comb begin
      tick       = (prescale_q == SCAN_DIV);
      prescale_d = tick ? 32'd0 : prescale_q + 32'd1;
      sub_wrap   = tick && (sub_q == 3'd7);
      sub_d      = tick ? sub_q + 3'd1 : sub_q;
      frame_wrap = sub_wrap && (idx_q >= IDX_LAST);
      idx_d      = idx_q;
      if (sub_wrap) begin
         idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
      end
   end

   // Blink phase flips every BLINK_FRAMES completed frames
   always_comb begin
      frame_d     = frame_q;
      blink_off_d = blink_off_q;
      if (frame_wrap) begin
         if (frame_q >= FRAME_LAST) begin
            frame_d     = 8'd0;
            blink_off_d = ~blink_off_q;
         end else begin
            frame_d = frame_q + 8'd1;
         end
      end
   end

   // Requests merge into one pending capture, taken at the frame boundary (including a request on that very cycle)
   always_comb begin
      capture     = frame_wrap && (pending_q || upd_req);
      pending_d   = pending_q || upd_req;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      if (capture) begin
         pending_d   = 1'b0;
         shadow_d    = display;
         shadow_dp_d = dp_in;
      end
   end

   // Pick the digit that will be active after this edge and decide whether it lights
   always_comb begin
      enable_d   = {NUM_DIGITS{ENABLE_OFF}};
      nibble_sel = 4'd0;
      dp_sel     = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == 3'(i)) begin
            nibble_sel = shadow_d[4*i +: 4];
            dp_sel     = shadow_dp_d[i];
            if ((sub_d <= bright) && !blank[i] && !(blink_en[i] && blink_off_d)) begin
               enable_d[i] = ENABLE_ON;
            end
         end
      end
   end

   hex7seg_dec u_dec (
      .nibble_i (nibble_sel),
      .seg_o    (dec_seg)
   );

   // Segments and dp follow the enable decision so a dark digit never shows stale glyphs
   always_comb begin
      digit_lit = (enable_d != {NUM_DIGITS{ENABLE_OFF}});
      segs_d    = digit_lit ? dec_seg : SEG_BLANK;
      dp_d      = digit_lit ? ~dp_sel : DP_OFF;
   end

   // Scan timing registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_q <= 32'd0;
         sub_q      <= 3'd0;
         idx_q      <= 3'd0;
      end else begin
         prescale_q <= prescale_d;
         sub_q      <= sub_d;
         idx_q      <= idx_d;
      end
   end

   // Blink registers; phase starts lit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q     <= 8'd0;
         blink_off_q <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         blink_off_q <= blink_off_d;
      end
   end

   // Pending flag and shadow; reset drops any outstanding request silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q   <= 1'b0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
      end else begin
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
      end
   end

   // Pin drivers update together on one edge to avoid ghosting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_q <= {NUM_DIGITS{ENABLE_OFF}};
         segs_q   <= SEG_BLANK;
         dp_q     <= DP_OFF;
      end else begin
         enable_q <= enable_d;
         segs_q   <= segs_d;
         dp_q     <= dp_d;
      end
   end

   assign enable     = enable_q;
   assign segs       = segs_q;
   assign dp         = dp_q;
   assign frame_done = frame_wrap;
   assign upd_ack    = capture;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (8-digit and 5-digit instances)
module tb_seg_scan_ctrl;

   localparam int P  = 4;   // SCAN_DIV + 1
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] display = '0;
   logic [7:0]  dp_in = '0, blank = '0, blink_en = '0;
   logic [2:0]  bright = 3'd7;
   logic        upd_req = 1'b0;

   logic [7:0]  enable8;
   logic [6:0]  segs8;
   logic        dp8, ack8, fd8;
   logic [4:0]  enable5;
   logic [6:0]  segs5;
   logic        dp5, ack5, fd5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(32'd3), .BLINK_FRAMES(2)) dut8 (
      .clk(clk), .rst(rst), .display(display), .dp_in(dp_in), .blank(blank),
      .blink_en(blink_en), .bright(bright), .upd_req(upd_req), .upd_ack(ack8),
      .enable(enable8), .segs(segs8), .dp(dp8), .frame_done(fd8));

   seg_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(32'd3), .BLINK_FRAMES(2)) dut5 (
      .clk(clk), .rst(rst), .display(display[19:0]), .dp_in(dp_in[4:0]), .blank(blank[4:0]),
      .blink_en(blink_en[4:0]), .bright(bright), .upd_req(upd_req), .upd_ack(ack5),
      .enable(enable5), .segs(segs5), .dp(dp5), .frame_done(fd5));

   // Reference glyphs
   logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Model: c = clock edges since reset release; everything else follows from c
   int          c = 0;
   int          nd [2] = '{8, 5};
   bit          pend [2];
   logic [31:0] shd [2];
   logic [7:0]  shdp [2];
   logic [2:0]  m_bright = '0;
   logic [7:0]  m_blank = '0, m_blink = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_wrap(input int d, input int cc);
      int fp = P * 8 * nd[d];
      return (cc % fp) == fp - 1;
   endfunction

   // Model advance on every clock edge
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            c = 0;
            for (int d = 0; d < 2; d++) begin
               pend[d] = 0; shd[d] = '0; shdp[d] = '0;
            end
         end else begin
            for (int d = 0; d < 2; d++) begin
               if (is_wrap(d, c) && (pend[d] || upd_req)) begin
                  shd[d] = display; shdp[d] = dp_in; pend[d] = 0;
               end else if (upd_req) begin
                  pend[d] = 1;
               end
            end
            m_bright = bright; m_blank = blank; m_blink = blink_en;
            c++;
         end
      end
   end

   // Per-cycle compare of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int d = 0; d < 2; d++) begin
               logic [7:0] e_en, a_en;
               logic [6:0] e_sg, a_sg;
               logic       e_dp, a_dp, a_fd, a_ack, w;
               int         idx, sub, frames;
               bit         off, lit;
               e_en = 8'hFF; e_sg = 7'h7F; e_dp = 1'b1;
               if (c > 0) begin
                  sub    = (c / P) % 8;
                  idx    = (c / (8 * P)) % nd[d];
                  frames = c / (8 * P * nd[d]);
                  off    = ((frames / BF) % 2) == 1;
                  lit    = (sub <= int'(m_bright)) && !m_blank[idx] && !(m_blink[idx] && off);
                  if (lit) begin
                     e_en[idx] = 1'b0;
                     e_sg = tbl[(shd[d] >> (4 * idx)) & 32'hF];
                     e_dp = ~shdp[d][idx];
                  end
               end
               w     = is_wrap(d, c);
               a_en  = (d == 0) ? enable8 : {3'b111, enable5};
               a_sg  = (d == 0) ? segs8 : segs5;
               a_dp  = (d == 0) ? dp8 : dp5;
               a_fd  = (d == 0) ? fd8 : fd5;
               a_ack = (d == 0) ? ack8 : ack5;
               chk($sformatf("enable_n%0d", nd[d]), 32'(a_en), 32'(e_en));
               chk($sformatf("segs_n%0d", nd[d]), 32'(a_sg), 32'(e_sg));
               chk($sformatf("dp_n%0d", nd[d]), 32'(a_dp), 32'(e_dp));
               chk($sformatf("frame_done_n%0d", nd[d]), 32'(a_fd), 32'(w));
               chk($sformatf("upd_ack_n%0d", nd[d]), 32'(a_ack), 32'(w && (pend[d] || upd_req)));
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_fd(input int d, input string nm);
      bit seen = 0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         @(negedge clk);
         seen = (d == 0) ? fd8 : fd5;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk({nm, "_enable8"}, 32'(enable8), 32'hFF);
      chk({nm, "_enable5"}, 32'(enable5), 32'h1F);
      chk({nm, "_segs"}, 32'(segs8), 32'h7F);
      chk({nm, "_dp_ack_fd"}, {29'd0, dp8, ack8, fd8}, 32'd4);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic count_digit(input logic [7:0] pat, output int n);
      n = 0;
      for (int r = 0; r < 256; r++) begin
         @(posedge clk); #1;
         if (enable8 == pat) n++;
      end
   endtask

   initial begin
      int n, acks;
      int lit0 [6];
      int lit7 [6];
      int exp0 [6] = '{31, 32, 0, 0, 32, 32};
      logic [4:0] e5;
      bit found;

      // Reset state, then first lit digit after release
      @(negedge clk);
      chk("rst_enable", 32'(enable8), 32'hFF);
      chk("rst_segs_dp", {24'd0, segs8, dp8}, 32'hFF);
      chk("rst_ack_fd", {30'd0, ack8, fd8}, 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("first_enable", 32'(enable8), 32'hFE);
      chk("first_segs", 32'(segs8), 32'b0000001);

      // Reset with an update pending discards it
      next_cycle(); display = 32'hFFFFFFFF; upd_req = 1'b1;
      next_cycle(); upd_req = 1'b0;
      repeat (50) next_cycle();
      do_reset("midrst");
      wait_fd(0, "fd_after_rst");
      chk("no_ack_after_rst", 32'(ack8), 32'd0);
      found = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(posedge clk); #1;
         found = (enable8 == 8'hFE);
      end
      chk("shadow_kept_zero", 32'(segs8), 32'b0000001);

      // Capture of 89ABCDEF, glyphs and slot widths at full brightness
      next_cycle(); display = 32'h89ABCDEF; upd_req = 1'b1; bright = 3'd7;
      next_cycle(); upd_req = 1'b0;
      wait_fd(0, "fd_capture");
      chk("ack_at_fd", 32'(ack8), 32'd1);
      lit0[0] = 0; lit7[0] = 0;
      for (int r = 0; r < 256; r++) begin
         @(posedge clk); #1;
         if (enable8 == 8'hFE) begin lit0[0]++; chk("glyph_F", 32'(segs8), 32'b0111000); end
         if (enable8 == 8'h7F) begin lit7[0]++; chk("glyph_8", 32'(segs8), 32'b0000000); end
      end
      chk("d0_width", lit0[0], 32);
      chk("d7_width", lit7[0], 32);
      @(negedge clk);
      chk("fd_period_256", 32'(fd8), 32'd1);

      // Five-digit instance: index 0..4,0 over one 160-cycle frame
      wait_fd(1, "fd5_start");
      for (int r = 0; r <= 160; r++) begin
         @(posedge clk); #1;
         e5 = ~(5'b00001 << ((r / 32) % 5));
         chk("idx_seq_n5", 32'(enable5), 32'(e5));
      end

      // Brightness duty
      next_cycle(); bright = 3'd0;
      wait_fd(0, "fd_bright0");
      count_digit(8'hFE, n);
      chk("duty_bright0", n, 4);
      next_cycle(); bright = 3'd3;
      wait_fd(0, "fd_bright3");
      count_digit(8'hFE, n);
      chk("duty_bright3", n, 16);

      // Two requests (10 cycles early and on the boundary) merge into one ack
      next_cycle(); bright = 3'd7;
      wait_fd(0, "fd_merge");
      acks = 0;
      for (int j = 1; j <= 256; j++) begin
         next_cycle();
         upd_req = (j == 246 || j == 256);
         display = (j == 256) ? 32'h76543210 : 32'h11111111;
         @(negedge clk);
         if (ack8) acks++;
      end
      next_cycle(); upd_req = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (ack8) acks++;
      end
      chk("merged_acks", acks, 1);
      found = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(posedge clk); #1;
         found = (enable8 == 8'hFE);
      end
      chk("latest_value", 32'(segs8), 32'b0000001);

      // Blink on digit 0, blank on digit 7, frames counted from reset
      blink_en = 8'h01; blank = 8'h80; bright = 3'd7;
      do_reset("blinkrst");
      for (int f = 0; f < 6; f++) begin lit0[f] = 0; lit7[f] = 0; end
      for (int cc = 1; cc < 1536; cc++) begin
         @(posedge clk); #1;
         if (!enable8[0]) lit0[cc / 256]++;
         if (!enable8[7]) lit7[cc / 256]++;
      end
      for (int f = 0; f < 6; f++) begin
         chk($sformatf("blink_d0_frame%0d", f), lit0[f], exp0[f]);
         chk($sformatf("blank_d7_frame%0d", f), lit7[f], 0);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         next_cycle();
         bright   = 3'($urandom_range(0, 7));
         blank    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         blink_en = 8'($urandom);
         dp_in    = 8'($urandom);
         display  = $urandom;
         upd_req  = ($urandom_range(0, 39) == 0);
         if (k == 1700) begin
            upd_req = 1'b0;
            do_reset("randrst");
         end
      end
      next_cycle(); upd_req = 1'b0;
      repeat (4) next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
